// File: rtl/kmeans_point_buffer_pkg.sv
// ============================================================================
// kmeans_point_buffer_pkg : shared defaults, FSM encoding and helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package kmeans_point_buffer_pkg;

   localparam int D_DEF = 4;
   localparam int W_DEF = 8;
   localparam int N_DEF = 128;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_FULL   = 2'd2,
      ST_STREAM = 2'd3
   } pb_state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/kmeans_point_buffer_ram.sv
// ============================================================================
// kmeans_point_buffer_ram : single-port synchronous RAM, 1-cycle read latency
// Rev 1.0
// ============================================================================
`default_nettype none

module kmeans_point_buffer_ram
   import kmeans_point_buffer_pkg::*;
#(
   parameter int DEPTH = N_DEF,
   parameter int WIDTH = D_DEF * W_DEF,
   parameter int AW    = $clog2(N_DEF)
) (
   input  logic             clk,
   input  logic             we,
   input  logic             re,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= din;
      if (re) dout <= mem[addr];
   end

endmodule

`default_nettype wire

// File: rtl/kmeans_point_buffer.sv
// ============================================================================
// kmeans_point_buffer : load one dataset of N points, replay it on request.
// Optional per-dimension min/max tracking under KMEANS_PB_MINMAX_EN. Rev 1.0
// ============================================================================
`default_nettype none

module kmeans_point_buffer
   import kmeans_point_buffer_pkg::*;
#(
   parameter int D = D_DEF,
   parameter int W = W_DEF,
   parameter int N = N_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [D*W-1:0]   in_point,
   output logic             load_done,
   input  logic             pass_start,
   output logic [D*W-1:0]   point_flat,
   output logic             point_valid,
   input  logic             point_ready,
   output logic             point_last,
   output logic             pass_done,
   output logic [7:0]       pass_count,
   output logic             busy
`ifdef KMEANS_PB_MINMAX_EN
   ,
   output logic [D*W-1:0]   dim_min_flat,
   output logic [D*W-1:0]   dim_max_flat
`endif
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int PW = D * W;
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   pb_state_t     state;
   logic [IW-1:0] wr_idx;
   logic [IW-1:0] rd_idx;
   logic          rd_done;
   logic          inflight;
   logic          inflight_last;
   logic [PW-1:0] buf0;
   logic [PW-1:0] buf1;
   logic          last0;
   logic          last1;
   logic [1:0]    cnt;
   logic [PW-1:0] ram_dout;

   logic          wr_en;
   logic          pop;
   logic [2:0]    occ;
   logic          rd_en;
   logic [IW-1:0] addr;

   assign wr_en = (state == ST_LOAD) && in_valid;
   assign pop   = (cnt != 2'd0) && point_ready;
   // Occupancy the skid will have once the in-flight read lands; keeps it at most 2.
   assign occ   = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};
   assign rd_en = (state == ST_STREAM) && !rd_done && (occ < 3'd2);
   assign addr  = (state == ST_LOAD) ? wr_idx : rd_idx;

   kmeans_point_buffer_ram #(
      .DEPTH (N),
      .WIDTH (PW),
      .AW    (IW)
   ) u_ram (
      .clk  (clk),
      .we   (wr_en),
      .re   (rd_en),
      .addr (addr),
      .din  (in_point),
      .dout (ram_dout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         wr_idx        <= '0;
         rd_idx        <= '0;
         rd_done       <= 1'b0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         buf0          <= '0;
         buf1          <= '0;
         last0         <= 1'b0;
         last1         <= 1'b0;
         cnt           <= 2'd0;
         pass_done     <= 1'b0;
         pass_count    <= 8'd0;
      end else begin
         pass_done     <= 1'b0;
         inflight      <= rd_en;
         inflight_last <= rd_en && (rd_idx == LAST_IDX);

         if (rd_en) begin
            if (rd_idx == LAST_IDX) rd_done <= 1'b1;
            else                    rd_idx  <= rd_idx + 1'b1;
         end

         if (inflight && !pop) begin
            if (cnt == 2'd0) begin
               buf0  <= ram_dout;
               last0 <= inflight_last;
            end else begin
               buf1  <= ram_dout;
               last1 <= inflight_last;
            end
            cnt <= cnt + 2'd1;
         end else if (!inflight && pop) begin
            buf0 <= buf1;
            last0 <= last1;
            cnt  <= cnt - 2'd1;
         end else if (inflight && pop) begin
            if (cnt == 2'd1) begin
               buf0  <= ram_dout;
               last0 <= inflight_last;
            end else begin
               buf0  <= buf1;
               last0 <= last1;
               buf1  <= ram_dout;
               last1 <= inflight_last;
            end
         end

         case (state)
            ST_IDLE: begin
               if (load_start) begin
                  state  <= ST_LOAD;
                  wr_idx <= '0;
               end
            end
            ST_LOAD: begin
               if (wr_en) begin
                  if (wr_idx == LAST_IDX) begin
                     state      <= ST_FULL;
                     wr_idx     <= '0;
                     pass_count <= 8'd0;
                  end else begin
                     wr_idx <= wr_idx + 1'b1;
                  end
               end
            end
            ST_FULL: begin
               if (load_start) begin
                  state  <= ST_LOAD;
                  wr_idx <= '0;
               end else if (pass_start) begin
                  state   <= ST_STREAM;
                  rd_idx  <= '0;
                  rd_done <= 1'b0;
               end
            end
            ST_STREAM: begin
               if (pop && last0) begin
                  state      <= ST_FULL;
                  pass_done  <= 1'b1;
                  pass_count <= sat_inc8(pass_count);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready    = (state == ST_LOAD);
   assign load_done   = (state == ST_FULL) || (state == ST_STREAM);
   assign busy        = (state == ST_LOAD) || (state == ST_STREAM);
   assign point_valid = (cnt != 2'd0);
   assign point_last  = (cnt != 2'd0) && last0;
   assign point_flat  = buf0;

`ifdef KMEANS_PB_MINMAX_EN
   for (genvar d = 0; d < D; d++) begin : g_dim
      logic signed [W-1:0] mn;
      logic signed [W-1:0] mx;
      logic signed [W-1:0] v;

      assign v = $signed(in_point[d*W +: W]);

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            mn <= '0;
            mx <= '0;
         end else if (wr_en) begin
            // The first write of a load seeds both bounds.
            if (wr_idx == '0) begin
               mn <= v;
               mx <= v;
            end else begin
               if (v < mn) mn <= v;
               if (v > mx) mx <= v;
            end
         end
      end

      assign dim_min_flat[d*W +: W] = mn;
      assign dim_max_flat[d*W +: W] = mx;
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_kmeans_point_buffer.sv
// ============================================================================
// tb_kmeans_point_buffer : directed self-checking bench for kmeans_point_buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_kmeans_point_buffer;

   localparam int D  = 4;
   localparam int W  = 8;
   localparam int N  = 128;
   localparam int PW = D * W;

   typedef struct {
      logic [PW-1:0] pt;
      logic          last;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          load_start = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [PW-1:0] in_point = '0;
   logic          load_done;
   logic          pass_start = 1'b0;
   logic [PW-1:0] point_flat;
   logic          point_valid;
   logic          point_ready = 1'b0;
   logic          point_last;
   logic          pass_done;
   logic [7:0]    pass_count;
   logic          busy;
`ifdef KMEANS_PB_MINMAX_EN
   logic [PW-1:0] dim_min_flat;
   logic [PW-1:0] dim_max_flat;
`endif

   int   total = 0;
   int   bad   = 0;
   vec_t tbl [N];

   kmeans_point_buffer #(.D(D), .W(W), .N(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .load_start  (load_start),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_point    (in_point),
      .load_done   (load_done),
      .pass_start  (pass_start),
      .point_flat  (point_flat),
      .point_valid (point_valid),
      .point_ready (point_ready),
      .point_last  (point_last),
      .pass_done   (pass_done),
      .pass_count  (pass_count),
      .busy        (busy)
`ifdef KMEANS_PB_MINMAX_EN
      ,
      .dim_min_flat(dim_min_flat),
      .dim_max_flat(dim_max_flat)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_in_ready"},    64'(in_ready),    64'd0);
      chk({tag, "_load_done"},   64'(load_done),   64'd0);
      chk({tag, "_point_valid"}, 64'(point_valid), 64'd0);
      chk({tag, "_point_last"},  64'(point_last),  64'd0);
      chk({tag, "_pass_done"},   64'(pass_done),   64'd0);
      chk({tag, "_busy"},        64'(busy),        64'd0);
      chk({tag, "_point_flat"},  64'(point_flat),  64'd0);
      chk({tag, "_pass_count"},  64'(pass_count),  64'd0);
   endtask

   // Loads N points from tbl; mm replaces dim0 with a signed extreme pattern.
   task automatic do_load(input bit pulse, input bit mm);
      int            wcnt = 0;
      int            cyc  = 0;
      bit            acc;
      logic [PW-1:0] p;
      logic [W-1:0]  mmv [4];
      mmv[0] = 8'hFB;
      mmv[1] = 8'h03;
      mmv[2] = 8'h80;
      mmv[3] = 8'h7F;
      if (pulse) begin
         load_start = 1'b1;
         tick();
         load_start = 1'b0;
      end
      while (wcnt < N && cyc < 4 * N + 100) begin
         p = tbl[wcnt].pt;
         if (mm) p[W-1:0] = mmv[wcnt % 4];
         in_point = p;
         in_valid = ($urandom_range(1) == 1);
         acc = in_valid && in_ready;
         tick();
         if (acc) wcnt++;
         cyc++;
      end
      in_valid = 1'b0;
      chk("load_writes", 64'(wcnt), 64'(N));
      chk("load_in_ready_low", 64'(in_ready), 64'd0);
      chk("load_done_high", 64'(load_done), 64'd1);
      chk("load_pass_count", 64'(pass_count), 64'd0);
      in_valid = 1'b1;
      tick();
      tick();
      in_valid = 1'b0;
      chk("load_in_ready_stays_low", 64'(in_ready), 64'd0);
   endtask

   task automatic run_pass(input int pct, input int inj_at, input int abort_at, input int exp_pc);
      int            idx = 0;
      int            cyc = 0;
      bit            acc;
      bit            stalled = 1'b0;
      logic [PW-1:0] prev = '0;
      point_ready = 1'b1;
      pass_start  = 1'b1;
      tick();
      pass_start = 1'b0;
      chk("lat_e0", 64'(point_valid), 64'd0);
      tick();
      chk("lat_e1", 64'(point_valid), 64'd0);
      tick();
      chk("lat_e2", 64'(point_valid), 64'd1);
      while (idx < N && cyc < 20 * N) begin
         if (abort_at >= 0 && idx == abort_at) return;
         point_ready = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
         pass_start  = (cyc == inj_at);
         if (pct >= 100) chk("no_bubble", 64'(point_valid), 64'd1);
         if (point_valid) begin
            chk("pt_data", 64'(point_flat), 64'(tbl[idx].pt));
            chk("pt_last", 64'(point_last), 64'(tbl[idx].last));
         end
         if (stalled) begin
            chk("stall_valid", 64'(point_valid), 64'd1);
            chk("stall_hold", 64'(point_flat), 64'(prev));
         end
         acc     = point_valid && point_ready;
         stalled = point_valid && !point_ready;
         prev    = point_flat;
         tick();
         cyc++;
         pass_start = 1'b0;
         if (acc) begin
            idx++;
            if (idx == N) begin
               chk("pass_done_pulse", 64'(pass_done), 64'd1);
               chk("pass_count", 64'(pass_count), 64'(exp_pc));
            end
         end
      end
      point_ready = 1'b0;
      pass_start  = 1'b0;
      chk("pass_len", 64'(idx), 64'(N));
      tick();
      chk("pass_done_single", 64'(pass_done), 64'd0);
      chk("pass_end_valid", 64'(point_valid), 64'd0);
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         for (int d = 0; d < D; d++) tbl[i].pt[d*W +: W] = W'(i + d);
         tbl[i].last = (i == N - 1);
      end

      // Reset state
      tick();
      tick();
      check_all_zero("reset");
      rst = 1'b0;
      tick();

      // T1 load with random source valid
      do_load(1'b1, 1'b0);

      // T2 full-rate replay
      run_pass(100, -1, -1, 1);

      // T3 reload, then three backpressured passes
      do_load(1'b1, 1'b0);
      for (int p = 1; p <= 3; p++) run_pass(30, -1, -1, p);
      chk("t3_pass_count", 64'(pass_count), 64'd3);

      // T4 pass_start during STREAM is ignored
      run_pass(100, 10, -1, 4);
      for (int i = 0; i < 5; i++) tick();
      chk("t4_no_extra_pass", 64'(point_valid), 64'd0);
      chk("t4_idle_busy", 64'(busy), 64'd0);
      chk("t4_pass_count", 64'(pass_count), 64'd4);

      // T4 load_start and pass_start together in FULL: load wins
      load_start = 1'b1;
      pass_start = 1'b1;
      tick();
      load_start = 1'b0;
      pass_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("t4_col_valid", 64'(point_valid), 64'd0);
         tick();
      end
      chk("t4_col_load_done", 64'(load_done), 64'd0);
      chk("t4_col_in_ready", 64'(in_ready), 64'd1);
      chk("t4_col_busy", 64'(busy), 64'd1);
      do_load(1'b0, 1'b0);

      // T5 asynchronous reset in the middle of a pass
      run_pass(100, -1, 60, 1);
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("t5_rst");
      tick();
      rst = 1'b0;
      pass_start = 1'b1;
      tick();
      pass_start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("t5_pass_ignored_valid", 64'(point_valid), 64'd0);
      chk("t5_pass_ignored_busy", 64'(busy), 64'd0);
      chk("t5_load_done", 64'(load_done), 64'd0);

`ifdef KMEANS_PB_MINMAX_EN
      // T6 signed min/max of dim0
      do_load(1'b1, 1'b1);
      chk("t6_dim0_min", 64'(dim_min_flat[W-1:0]), 64'h80);
      chk("t6_dim0_max", 64'(dim_max_flat[W-1:0]), 64'h7F);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
